// File: rtl/bram_dual_pkg.sv
// Shared types and helpers for the bram_dual true dual-port RAM family.
package bram_dual_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bram_dual_outpipe.sv
// Per-port output stage: optional extra register with valid (and parity error) alignment.
// Parity error path exists only when BRAM_DUAL_PARITY_EN is defined.
module bram_dual_outpipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
`ifdef BRAM_DUAL_PARITY_EN
  input  logic             in_perr,
  output logic             out_perr,
`endif
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  if (OUT_REG != 0) begin : g_reg
    logic             vld_reg;
    logic [WIDTH-1:0] data_reg;

    // Data only moves on a valid beat so DO holds across idle cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        vld_reg  <= 1'b0;
        data_reg <= '0;
      end else begin
        vld_reg <= in_vld;
        if (in_vld) data_reg <= in_data;
      end
    end

    assign out_vld  = vld_reg;
    assign out_data = data_reg;

`ifdef BRAM_DUAL_PARITY_EN
    logic perr_reg;
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) perr_reg <= 1'b0;
      else        perr_reg <= in_perr;
    end
    assign out_perr = perr_reg;
`endif
  end else begin : g_pass
    logic unused_clk;
    assign unused_clk = Clk ^ Rst_n;
    assign out_vld    = in_vld;
    assign out_data   = in_data;
`ifdef BRAM_DUAL_PARITY_EN
    assign out_perr   = in_perr;
`endif
  end

endmodule

// File: rtl/bram_dual_tdp.sv
// Parametrised true dual-port block RAM with clear sequencer and write-collision flag.
// Defining BRAM_DUAL_PARITY_EN adds a stored even-parity bit per word and Perr_A/Perr_B.
module bram_dual_tdp
  import bram_dual_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 64,
  parameter int               RDW_MODE = 0,
  parameter int               OUT_REG  = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              AW       = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clr,
  output logic             Busy,
  input  logic             En_A,
  input  logic             En_B,
  input  logic             We_A,
  input  logic             We_B,
  input  logic [AW-1:0]    Addr_A,
  input  logic [AW-1:0]    Addr_B,
  input  logic [WIDTH-1:0] DI_A,
  input  logic [WIDTH-1:0] DI_B,
  output logic [WIDTH-1:0] DO_A,
  output logic [WIDTH-1:0] DO_B,
  output logic             Vld_A,
  output logic             Vld_B,
`ifdef BRAM_DUAL_PARITY_EN
  output logic             Perr_A,
  output logic             Perr_B,
`endif
  output logic             Coll
);

`ifdef BRAM_DUAL_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  function automatic logic [MW-1:0] pack_word(input logic [WIDTH-1:0] d);
`ifdef BRAM_DUAL_PARITY_EN
    return {even_parity(64'(d)), d};
`else
    return d;
`endif
  endfunction

  state_t               state_reg, state_next;
  logic [AW-1:0]        ptr_reg, ptr_next;
  logic [MW-1:0]        mem [DEPTH];
  logic [1:0]           acc_w, we_w;
  logic [1:0][AW-1:0]   addr_w;
  logic [1:0][MW-1:0]   wd_w;
  logic [MW-1:0]        init_word;
  logic                 coll_reg;

  assign Busy      = (state_reg == CLEAR);
  assign acc_w     = {En_B, En_A} & {2{~Busy}};
  assign we_w      = {We_B, We_A};
  assign addr_w    = {Addr_B, Addr_A};
  assign wd_w      = {pack_word(DI_B), pack_word(DI_A)};
  assign init_word = pack_word(INIT_VAL);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      CLEAR: begin
        ptr_next = ptr_reg + AW'(1);
        if (ptr_reg == AW'(DEPTH - 1)) state_next = READY;
      end
      READY: begin
        if (Clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Port B is written first so that port A wins a same-address collision.
  always_ff @(posedge Clk) begin
    if (Busy) begin
      mem[ptr_reg] <= init_word;
    end else begin
      if (acc_w[1] && we_w[1]) mem[addr_w[1]] <= wd_w[1];
      if (acc_w[0] && we_w[0]) mem[addr_w[0]] <= wd_w[0];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) coll_reg <= 1'b0;
    else        coll_reg <= &(acc_w & we_w) && (addr_w[0] == addr_w[1]);
  end
  assign Coll = coll_reg;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    logic [MW-1:0]    rd_reg;
    logic             rd_vld_reg;
    logic [WIDTH-1:0] dout_w;
    logic             vout_w;

    // Array reads see pre-edge contents, giving old data to the other port.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        rd_reg     <= '0;
        rd_vld_reg <= 1'b0;
      end else begin
        rd_vld_reg <= acc_w[gi];
        if (acc_w[gi]) begin
          if (we_w[gi] && RDW_MODE == RDW_WRITE_FIRST) rd_reg <= wd_w[gi];
          else                                         rd_reg <= mem[addr_w[gi]];
        end
      end
    end

`ifdef BRAM_DUAL_PARITY_EN
    logic perr_w;
    logic perr_out_w;
    assign perr_w = rd_vld_reg && (even_parity(64'(rd_reg[WIDTH-1:0])) != rd_reg[WIDTH]);
`endif

    bram_dual_outpipe #(
      .WIDTH  (WIDTH),
      .OUT_REG(OUT_REG)
    ) u_outpipe (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .in_vld  (rd_vld_reg),
      .in_data (rd_reg[WIDTH-1:0]),
`ifdef BRAM_DUAL_PARITY_EN
      .in_perr (perr_w),
      .out_perr(perr_out_w),
`endif
      .out_vld (vout_w),
      .out_data(dout_w)
    );
  end

  assign DO_A  = g_port[0].dout_w;
  assign DO_B  = g_port[1].dout_w;
  assign Vld_A = g_port[0].vout_w;
  assign Vld_B = g_port[1].vout_w;
`ifdef BRAM_DUAL_PARITY_EN
  assign Perr_A = g_port[0].perr_out_w;
  assign Perr_B = g_port[1].perr_out_w;
`endif

endmodule

// File: tb/tb_bram_dual_tdp.sv
// Scoreboard bench for bram_dual_tdp: read-first/no-outreg and write-first/outreg instances share stimulus.
module tb_bram_dual_tdp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] INIT0 = 32'hA5A5_A5A5;
  localparam logic [31:0] INIT1 = 32'h0000_3C3C;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clr    = 1'b0;
  logic        en_a   = 1'b0;
  logic        en_b   = 1'b0;
  logic        we_a   = 1'b0;
  logic        we_b   = 1'b0;
  logic [5:0]  addr_a = '0;
  logic [5:0]  addr_b = '0;
  logic [31:0] di_a   = '0;
  logic [31:0] di_b   = '0;

  logic [31:0] do_s   [4];
  logic        vld_s  [4];
  logic        busy_s [2];
  logic        coll_s [2];

  always #5 clk = ~clk;

  bram_dual_tdp #(
    .WIDTH(32), .DEPTH(DEPTH), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(INIT0)
  ) dut0 (
    .Clk(clk), .Rst_n(rst_n), .Clr(clr), .Busy(busy_s[0]),
    .En_A(en_a), .En_B(en_b), .We_A(we_a), .We_B(we_b),
    .Addr_A(addr_a), .Addr_B(addr_b), .DI_A(di_a), .DI_B(di_b),
    .DO_A(do_s[0]), .DO_B(do_s[1]), .Vld_A(vld_s[0]), .Vld_B(vld_s[1]),
    .Coll(coll_s[0])
  );

  bram_dual_tdp #(
    .WIDTH(32), .DEPTH(DEPTH), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(INIT1)
  ) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Clr(clr), .Busy(busy_s[1]),
    .En_A(en_a), .En_B(en_b), .We_A(we_a), .We_B(we_b),
    .Addr_A(addr_a), .Addr_B(addr_b), .DI_A(di_a), .DI_B(di_b),
    .DO_A(do_s[2]), .DO_B(do_s[3]), .Vld_A(vld_s[2]), .Vld_B(vld_s[3]),
    .Coll(coll_s[1])
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  // Reference model: plain word arrays, a clear countdown and per-port expectation queues.
  exp_t        sb_q     [4][$];
  logic [31:0] ref_mem  [2][DEPTH];
  logic [31:0] last_dat [4] = '{default: '0};
  int          lat_of   [2] = '{1, 2};
  int          rdw_of   [2] = '{0, 1};
  logic [31:0] init_of  [2] = '{INIT0, INIT1};
  string       pname    [4] = '{"dut0.A", "dut0.B", "dut1.A", "dut1.B"};
  int          busy_cnt = DEPTH;
  int          cyc      = 0;
  logic        exp_coll = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic model_update();
    exp_t e;
    cyc++;
    exp_coll = 1'b0;
    if (!rst_n) return;
    if (busy_cnt > 0) begin
      for (int d = 0; d < 2; d++) ref_mem[d][DEPTH - busy_cnt] = init_of[d];
      busy_cnt--;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (en_a) begin
        e.data = (we_a && rdw_of[d] == 1) ? di_a : ref_mem[d][addr_a];
        e.due  = 32'(cyc + lat_of[d] - 1);
        sb_q[2*d].push_back(e);
      end
      if (en_b) begin
        e.data = (we_b && rdw_of[d] == 1) ? di_b : ref_mem[d][addr_b];
        e.due  = 32'(cyc + lat_of[d] - 1);
        sb_q[2*d+1].push_back(e);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (en_b && we_b) ref_mem[d][addr_b] = di_b;
      if (en_a && we_a) ref_mem[d][addr_a] = di_a;
    end
    exp_coll = en_a && we_a && en_b && we_b && (addr_a == addr_b);
    if (clr) busy_cnt = DEPTH;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
      last_dat[k] = '0;
    end
    busy_cnt = DEPTH;
    exp_coll = 1'b0;
  endtask

  task automatic step(input logic ea, input logic wa, input logic [5:0] aa, input logic [31:0] da,
                      input logic eb, input logic wb, input logic [5:0] ab, input logic [31:0] db,
                      input logic c);
    en_a = ea; we_a = wa; addr_a = aa; di_a = da;
    en_b = eb; we_b = wb; addr_b = ab; di_b = db;
    clr  = c;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [5:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 7));
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic step_rand(input logic force_en_a, input logic c);
    step(force_en_a || ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
         ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rnd_addr(), $urandom(), c);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (do_s[k] !== 32'd0 || vld_s[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s_reset_out %s: DO=%h Vld=%b, required DO=0 Vld=0", tag, pname[k], do_s[k], vld_s[k]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_s[d] !== 1'b1 || coll_s[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s_reset_ctl dut%0d: Busy=%b Coll=%b, required Busy=1 Coll=0", tag, d, busy_s[d], coll_s[d]);
      end
    end
  endtask

  task automatic check_clear_length(input string tag);
    int n;
    n = 0;
    while (busy_s[0] === 1'b1 && n < 200) begin
      step_idle();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL %s_busy_len: Busy high for %0d cycles, required %0d", tag, n, DEPTH);
    end
    $display("clear %s: Busy high for %0d cycles", tag, n);
  endtask

  // Monitor: pops the scoreboard whenever a port presents Vld, otherwise checks hold and timeouts.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (vld_s[k] === 1'b1) begin
          checks++;
          if (sb_q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld %s cycle %0d: DO=%h with no access outstanding", pname[k], cyc, do_s[k]);
          end else begin
            exp_t e;
            e = sb_q[k].pop_front();
            if (do_s[k] !== e.data || e.due != 32'(cyc)) begin
              errors++;
              $display("FAIL read_data %s cycle %0d: DO=%h, required %h due at cycle %0d",
                       pname[k], cyc, do_s[k], e.data, e.due);
            end else begin
              $display("read %s cycle %0d: DO=%h", pname[k], cyc, do_s[k]);
            end
            last_dat[k] = e.data;
          end
        end else begin
          checks++;
          if (do_s[k] !== last_dat[k]) begin
            errors++;
            $display("FAIL hold_data %s cycle %0d: DO=%h, required held %h", pname[k], cyc, do_s[k], last_dat[k]);
          end
          if (sb_q[k].size() > 0 && sb_q[k][0].due <= 32'(cyc)) begin
            checks++;
            errors++;
            $display("FAIL missing_vld %s cycle %0d: Vld=0, required data %h", pname[k], cyc, sb_q[k][0].data);
            void'(sb_q[k].pop_front());
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (busy_s[d] !== (busy_cnt > 0)) begin
          errors++;
          $display("FAIL busy dut%0d cycle %0d: Busy=%b, required %b", d, cyc, busy_s[d], busy_cnt > 0);
        end
        checks++;
        if (coll_s[d] !== exp_coll) begin
          errors++;
          $display("FAIL coll dut%0d cycle %0d: Coll=%b, required %b", d, cyc, coll_s[d], exp_coll);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("power_on");
    rst_n = 1'b1;
    check_clear_length("power_on");

    // Freshly cleared corners, then same-port read-during-write on address 5.
    step(1'b1, 1'b0, 6'd0,  32'd0, 1'b1, 1'b0, 6'd63, 32'd0, 1'b0);
    step(1'b1, 1'b0, 6'd63, 32'd0, 1'b1, 1'b0, 6'd0,  32'd0, 1'b0);
    step(1'b1, 1'b1, 6'd5,  32'd7, 1'b0, 1'b0, 6'd0,  32'd0, 1'b0);
    step(1'b1, 1'b1, 6'd5,  32'd9, 1'b0, 1'b0, 6'd0,  32'd0, 1'b0);
    step(1'b1, 1'b0, 6'd5,  32'd0, 1'b0, 1'b0, 6'd0,  32'd0, 1'b0);

    // Write collision on address 10, then read back on both ports.
    step(1'b1, 1'b1, 6'd10, 32'd3, 1'b1, 1'b1, 6'd10, 32'd4, 1'b0);
    step(1'b1, 1'b0, 6'd10, 32'd0, 1'b1, 1'b0, 6'd10, 32'd0, 1'b0);

    // Cross-port: A writes 12 to 20 while B reads the old 1.
    step(1'b1, 1'b1, 6'd20, 32'd1,  1'b0, 1'b0, 6'd0,  32'd0, 1'b0);
    step(1'b1, 1'b1, 6'd20, 32'd12, 1'b1, 1'b0, 6'd20, 32'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0,  32'd0,  1'b1, 1'b0, 6'd20, 32'd0, 1'b0);

    // Back-to-back streaming reads on both ports.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(i), 32'd0, 1'b1, 1'b0, 6'(7 - i), 32'd0, 1'b0);
    repeat (3) step_idle();

    for (int i = 0; i < 1500; i++) step_rand(1'b0, 1'b0);

    // Clr with port A hammering: nothing accepted while the clear runs.
    step_rand(1'b1, 1'b1);
    for (int i = 0; i < 70; i++) step_rand(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) step_rand(1'b0, 1'b0);

    // Reset in the middle of a clear restarts the full sequence.
    step_rand(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step_rand(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("mid_clear");
    step_idle();
    rst_n = 1'b1;
    check_clear_length("after_reset");

    for (int i = 0; i < 300; i++) step_rand(1'b0, 1'b0);
    repeat (5) step_idle();

    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sb_q[k].size() != 0) begin
        errors++;
        $display("FAIL leftover %s: %0d reads never returned, required 0", pname[k], sb_q[k].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
